// File: rtl/snn_layer_sequencer.sv
// Config loader, timestep sequencer and spike counter for a 3-neuron layer.
// Optional SPIKE_RASTER_EN adds raster_valid/raster_spikes taps.
module snn_layer_sequencer #(
  parameter int TICK_DIV = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  input  logic [7:0]         cfg_data,
  output logic               cfg_ready,
  input  logic               start,
  input  logic [7:0]         num_steps,
  input  logic               abort,
  input  logic [2:0]         spike_in,
  output logic [71:0]        input_weights,
  output logic [31:0]        neuron_params,
  output logic               layer_enable,
  output logic               layer_reset,
  output logic               busy,
  output logic               done,
  output logic [3*CNT_W-1:0] spike_counts
`ifdef SPIKE_RASTER_EN
  ,
  output logic               raster_valid,
  output logic [2:0]         raster_spikes
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0]       TLAST = 8'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CMAX  = '1;

  state_t           state;
  logic [3:0]       idx;
  logic [103:0]     staging;
  logic [103:0]     staged;
  logic [7:0]       tick;
  logic [7:0]       tick_nxt;
  logic [7:0]       step;
  logic [7:0]       steps_q;
  logic [CNT_W-1:0] cnt [3];
  logic             accept;
  logic             sample;

  assign cfg_ready    = (state == IDLE);
  assign accept       = cfg_valid && cfg_ready;
  assign sample       = (state == RUN) && (tick == 8'd1);
  assign tick_nxt     = (tick == TLAST) ? 8'd0 : tick + 8'd1;
  assign spike_counts = {cnt[2], cnt[1], cnt[0]};

`ifdef SPIKE_RASTER_EN
  assign raster_valid  = sample && !abort;
  assign raster_spikes = raster_valid ? spike_in : 3'b000;
`endif

  always_comb begin
    staged = staging;
    for (int i = 0; i < 13; i++) begin
      if (idx == 4'(i)) staged[103-8*i -: 8] = cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      staging       <= '0;
      input_weights <= '0;
      neuron_params <= '0;
      layer_enable  <= 1'b0;
      layer_reset   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tick          <= '0;
      step          <= '0;
      steps_q       <= '0;
      for (int n = 0; n < 3; n++) cnt[n] <= '0;
    end else begin
      layer_enable <= 1'b0;
      layer_reset  <= 1'b0;
      done         <= 1'b0;
      if (accept) begin
        staging <= staged;
        if (idx == 4'd12) begin
          idx           <= '0;
          input_weights <= staged[103:32];
          neuron_params <= staged[31:0];
        end else begin
          idx <= idx + 4'd1;
        end
      end
      unique case (state)
        IDLE: begin
          if (start && idx == 4'd0) begin
            steps_q <= num_steps;
            if (num_steps == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= CLEAR;
              layer_reset <= 1'b1;
              busy        <= 1'b1;
              tick        <= '0;
              step        <= '0;
              for (int n = 0; n < 3; n++) cnt[n] <= '0;
            end
          end
        end
        CLEAR: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state        <= RUN;
            layer_enable <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tick         <= tick_nxt;
            layer_enable <= (tick_nxt == 8'd0);
            if (tick == 8'd0) step <= step + 8'd1;
            if (sample) begin
              for (int n = 0; n < 3; n++) begin
                if (spike_in[n] && cnt[n] != CMAX)
                  cnt[n] <= cnt[n] + 1'b1;
              end
              // step already counts the pulse this sample follows
              if (step == steps_q) begin
                state        <= DONE;
                busy         <= 1'b0;
                done         <= 1'b1;
                layer_enable <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
